// File: rtl/i2c_accel_pkg.sv
// Shared types and constants for the ADXL345-style I2C accelerometer target.
package i2c_accel_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK
  } state_t;

  localparam logic [5:0] REG_DEVID       = 6'h00;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h53;

  // bank layout is {Z_H, Z_L, Y_H, Y_L, X_H, X_L}, X_L in the low byte
  function automatic logic [7:0] reg_read(
    input logic [5:0]  addr,
    input logic [7:0]  devid,
    input logic [7:0]  power,
    input logic [7:0]  fmt,
    input logic [47:0] bank
  );
    logic [7:0] val;
    case (addr)
      REG_DEVID:             val = devid;
      REG_POWER_CTL:         val = power;
      REG_DATA_FORMAT:       val = fmt;
      REG_DATAX0:            val = bank[7:0];
      REG_DATAX0 + 6'd1:     val = bank[15:8];
      REG_DATAX0 + 6'd2:     val = bank[23:16];
      REG_DATAX0 + 6'd3:     val = bank[31:24];
      REG_DATAX0 + 6'd4:     val = bank[39:32];
      REG_DATAX0 + 6'd5:     val = bank[47:40];
      default:               val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_accel_target_bus_sync.sv
// SCL/SDA synchronizer with START/STOP/SCL-edge detection.
// Defining I2C_GLITCH_FILTER_EN adds a FILTER_LEN-deep stability filter after the synchronizer.
module i2c_bus_sync #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // bit 1 = SCL, bit 0 = SDA; the idle bus is high so everything resets to 1
  logic [1:0] meta;
  logic [1:0] synced;
  logic [1:0] clean;
  logic [1:0] prev;

  // two-flop synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 2'b11;
      synced <= 2'b11;
    end else begin
      meta   <= {scl_raw, sda_raw};
      synced <= meta;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    filt;
  logic [CW-1:0] cnt [2];

  // output follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt   <= 2'b11;
      cnt[0] <= {CW{1'b0}};
      cnt[1] <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == filt[i]) begin
          cnt[i] <= {CW{1'b0}};
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= synced[i];
          cnt[i]  <= {CW{1'b0}};
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign clean = filt;
`else
  logic [31:0] unused_filter_len;
  assign unused_filter_len = FILTER_LEN;
  assign clean = synced;
`endif

  // previous cleaned levels for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 2'b11;
    end else begin
      prev <= clean;
    end
  end

  assign sda       = clean[0];
  assign scl_rise  = clean[1] & ~prev[1];
  assign scl_fall  = ~clean[1] & prev[1];
  assign start_det = clean[1] & prev[1] & prev[0] & ~clean[0];
  assign stop_det  = clean[1] & prev[1] & ~prev[0] & clean[0];

endmodule

// File: rtl/i2c_accel_target.sv
// I2C target emulating an ADXL345-style accelerometer register file.
// Optional SCL/SDA glitch filter is enabled with the I2C_GLITCH_FILTER_EN macro.
module i2c_accel_target
  import i2c_accel_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter int         HOLD_CYCLES = 4,
  parameter int         FILTER_LEN  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        reg_wr_strobe,
  output logic [5:0]  reg_wr_addr,
  output logic        busy
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_raw   (i2c_scl),
    .sda_raw   (i2c_sda),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state, state_next;
  logic [3:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  shift, shift_next, rx_byte;
  logic [5:0]  ptr, ptr_next;
  logic [7:0]  tx, tx_next;
  logic        sda_low, sda_low_next;
  logic        rd, rd_next;
  logic        busy_next, wr_strobe_next, bank_load;
  logic [5:0]  wr_addr_next;
  logic [7:0]  power_next, format_next;
  logic [47:0] shadow, bank;
  logic [7:0]  hold_cnt;
  logic        hold_tick;

  assign i2c_sda   = sda_low ? 1'b0 : 1'bz;
  assign hold_tick = (hold_cnt == 8'd1);

  // SDA may only change HOLD_CYCLES after a falling SCL, well inside the low phase
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= 8'd0;
    end else if (scl_fall) begin
      hold_cnt <= HOLD_INIT;
    end else if (hold_cnt != 8'd0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end else begin
      hold_cnt <= hold_cnt;
    end
  end

  // shadow captures samples; bank freezes a coherent copy per read header
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= 48'h0;
      bank   <= 48'h0;
    end else begin
      if (sample_valid) begin
        shadow <= {sample_z, sample_y, sample_x};
      end
      if (bank_load) begin
        bank <= shadow;
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= 4'd0;
      shift         <= 8'h00;
      ptr           <= 6'h00;
      tx            <= 8'h00;
      sda_low       <= 1'b0;
      rd            <= 1'b0;
      busy          <= 1'b0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= 6'h00;
      power_ctl     <= 8'h00;
      data_format   <= 8'h00;
    end else begin
      state         <= state_next;
      bit_cnt       <= bit_cnt_next;
      shift         <= shift_next;
      ptr           <= ptr_next;
      tx            <= tx_next;
      sda_low       <= sda_low_next;
      rd            <= rd_next;
      busy          <= busy_next;
      reg_wr_strobe <= wr_strobe_next;
      reg_wr_addr   <= wr_addr_next;
      power_ctl     <= power_next;
      data_format   <= format_next;
    end
  end

  // next-state and datapath decode
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    ptr_next       = ptr;
    tx_next        = tx;
    sda_low_next   = sda_low;
    rd_next        = rd;
    busy_next      = busy;
    wr_strobe_next = 1'b0;
    wr_addr_next   = reg_wr_addr;
    power_next     = power_ctl;
    format_next    = data_format;
    bank_load      = 1'b0;
    rx_byte        = {shift[6:0], sda};

    if (stop_det) begin
      state_next   = ST_IDLE;
      sda_low_next = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      state_next   = ST_ADDR;
      bit_cnt_next = 4'd0;
      sda_low_next = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (hold_tick) begin
            sda_low_next = 1'b0;
          end else begin
            sda_low_next = sda_low;
          end
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_next = 4'd0;
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_next = ST_ADDR_ACK;
                  busy_next  = 1'b1;
                  rd_next    = rx_byte[0];
                  bank_load  = rx_byte[0];
                end else begin
                  state_next = ST_IDLE;
                end
              end else if (state == ST_PTR) begin
                ptr_next   = rx_byte[5:0];
                state_next = ST_PTR_ACK;
              end else begin
                state_next = ST_WACK;
              end
            end else begin
              state_next = state;
            end
          end else begin
            shift_next = shift;
          end
        end

        // ACK goes low after the 8th fall and is held until the next state's first tick
        ST_ADDR_ACK, ST_PTR_ACK, ST_WACK: begin
          if (hold_tick) begin
            sda_low_next = 1'b1;
          end else begin
            sda_low_next = sda_low;
          end
          if (scl_rise) begin
            bit_cnt_next = 4'd0;
            case (state)
              ST_ADDR_ACK: begin
                if (rd) begin
                  state_next = ST_RDATA;
                  tx_next    = reg_read(ptr, DEVID_VAL, power_ctl, data_format, bank);
                end else begin
                  state_next = ST_PTR;
                end
              end
              ST_PTR_ACK: state_next = ST_WDATA;
              default: begin
                case (ptr)
                  REG_POWER_CTL:   power_next  = shift;
                  REG_DATA_FORMAT: format_next = shift;
                  default:         power_next  = power_ctl;
                endcase
                wr_strobe_next = 1'b1;
                wr_addr_next   = ptr;
                ptr_next       = ptr + 6'd1;
                state_next     = ST_WDATA;
              end
            endcase
          end else begin
            state_next = state;
          end
        end

        ST_RDATA: begin
          if (hold_tick) begin
            if (bit_cnt == 4'd8) begin
              sda_low_next = 1'b0;
              state_next   = ST_RACK;
            end else begin
              sda_low_next = ~tx[~bit_cnt[2:0]];
            end
          end else begin
            sda_low_next = sda_low;
          end
          if (scl_rise) begin
            bit_cnt_next = bit_cnt + 4'd1;
          end else begin
            bit_cnt_next = bit_cnt;
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            if (sda) begin
              state_next = ST_IDLE;
            end else begin
              ptr_next     = ptr + 6'd1;
              tx_next      = reg_read(ptr + 6'd1, DEVID_VAL, power_ctl, data_format, bank);
              bit_cnt_next = 4'd0;
              state_next   = ST_RDATA;
            end
          end else begin
            state_next = state;
          end
        end

        default: begin
          sda_low_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_accel_target.sv
// Directed bench: a bit-banged I2C master drives the target and checks register traffic.
module tb_i2c_accel_target;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        m_sda_low;
  wire         sda_bus;
  logic        sample_valid;
  logic [15:0] sx, sy, sz;
  logic [7:0]  power_ctl, data_format;
  logic        reg_wr_strobe;
  logic [5:0]  reg_wr_addr;
  logic        busy;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_accel_target dut (
    .clk           (clk),
    .reset         (reset),
    .i2c_scl       (scl),
    .i2c_sda       (sda_bus),
    .sample_valid  (sample_valid),
    .sample_x      (sx),
    .sample_y      (sy),
    .sample_z      (sz),
    .power_ctl     (power_ctl),
    .data_format   (data_format),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .busy          (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int strobe_total = 0;
  int tgt_low_total = 0;

  always @(negedge clk) begin
    if (reg_wr_strobe === 1'b1) strobe_total++;
    if (sda_bus === 1'b0 && !m_sda_low) tgt_low_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; clks(Q);
    scl = 1'b1;       clks(Q);
    m_sda_low = 1'b1; clks(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    clks(Q); m_sda_low = 1'b1;
    clks(Q); scl = 1'b1;
    clks(Q); m_sda_low = 1'b0;
    clks(Q);
  endtask

  task automatic clock_bit(input logic v, output logic s);
    clks(Q); m_sda_low = ~v;
    clks(Q); scl = 1'b1;
    clks(Q); s = (sda_bus !== 1'b0);
    clks(Q); scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(nack, s);
  endtask

  logic [7:0] rd_buf [8];
  logic [2:0] r_acks;
  logic [3:0] w_acks;
  logic       busy_pre_stop;

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sx = x; sy = y; sz = z;
    sample_valid = 1'b1;
    clks(1);
    sample_valid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] p, input int n, input int pulse_at);
    logic a0, a1, a2;
    bus_start();
    wr_byte(8'hA6, a0);
    wr_byte({2'b00, p}, a1);
    bus_start();
    wr_byte(8'hA7, a2);
    for (int k = 0; k < n; k++) begin
      if (k == pulse_at) pulse_sample(16'hFFFF, 16'h5678, 16'h9ABC);
      rd_byte(k == n - 1, rd_buf[k]);
    end
    busy_pre_stop = busy;
    bus_stop();
    r_acks = {a0, a1, a2};
  endtask

  task automatic do_write(input logic [5:0] p, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic a0, a1, a2, a3;
    a3 = 1'b0;
    bus_start();
    wr_byte(8'hA6, a0);
    wr_byte({2'b00, p}, a1);
    wr_byte(d0, a2);
    if (n > 1) wr_byte(d1, a3);
    bus_stop();
    w_acks = {a0, a1, a2, a3};
  endtask

  typedef struct {
    logic       wr;
    logic [5:0] ptr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] exp6 [6];
  logic       ack, s;
  int         snap;

  initial begin
    tbl[0] = '{1'b1, 6'h31, 8'h0B, 8'h0B};
    tbl[1] = '{1'b0, 6'h2D, 8'h00, 8'h08};
    tbl[2] = '{1'b1, 6'h00, 8'h77, 8'hE5};
    tbl[3] = '{1'b1, 6'h32, 8'h55, 8'h34};
    tbl[4] = '{1'b0, 6'h37, 8'h00, 8'h9A};
    tbl[5] = '{1'b0, 6'h10, 8'h00, 8'h00};
    tbl[6] = '{1'b1, 6'h3F, 8'hAA, 8'h00};
    tbl[7] = '{1'b1, 6'h2D, 8'h01, 8'h01};
    exp6 = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};

    reset = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
    sample_valid = 1'b0; sx = 16'h0; sy = 16'h0; sz = 16'h0;
    clks(5);
    reset = 1'b0;
    clks(2);
    check("rst_power_ctl", power_ctl, 8'h00);
    check("rst_data_format", data_format, 8'h00);
    check("rst_strobe", reg_wr_strobe, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 6'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_sda_released", sda_bus !== 1'b0, 1'b1);

    // burst read of one coherent sample
    pulse_sample(16'h1234, 16'h5678, 16'h9ABC);
    do_read(6'h32, 6, -1);
    check("burst_acks", r_acks, 3'b000);
    for (int k = 0; k < 6; k++) check($sformatf("burst_byte%0d", k), rd_buf[k], exp6[k]);
    check("burst_busy_before_stop", busy_pre_stop, 1'b1);
    clks(4);
    check("burst_busy_after_stop", busy, 1'b0);

    // DEVID
    do_read(6'h00, 1, -1);
    check("devid_acks", r_acks, 3'b000);
    check("devid_value", rd_buf[0], 8'hE5);

    // burst write: second byte lands on unmapped 0x2E
    snap = strobe_total;
    do_write(6'h2D, 2, 8'h08, 8'h0B);
    check("wr_acks", w_acks, 4'b0000);
    check("wr_power_ctl", power_ctl, 8'h08);
    check("wr_strobe_count", strobe_total - snap, 2);
    check("wr_last_addr", reg_wr_addr, 6'h2E);
    check("wr_data_format", data_format, 8'h00);

    // table of write/read-back pairs
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].ptr, 1, tbl[i].data, 8'h00);
        check($sformatf("tbl%0d_wacks", i), w_acks, 4'b0000);
      end
      do_read(tbl[i].ptr, 1, -1);
      check($sformatf("tbl%0d_read", i), rd_buf[0], tbl[i].exp);
    end
    check("tbl_power_ctl", power_ctl, 8'h01);
    check("tbl_data_format", data_format, 8'h0B);

    // pointer wrap 0x3F -> 0x00
    do_read(6'h3F, 2, -1);
    check("wrap_byte0", rd_buf[0], 8'h00);
    check("wrap_byte1", rd_buf[1], 8'hE5);

    // foreign address is never acknowledged
    snap = tgt_low_total;
    bus_start();
    wr_byte(8'h3A, ack);
    check("wrong_addr_nack", ack, 1'b1);
    clks(2);
    check("wrong_addr_busy", busy, 1'b0);
    bus_stop();
    check("wrong_addr_no_drive", tgt_low_total - snap, 0);

    // a mid-burst sample update only shows up in the next burst
    do_read(6'h32, 6, 2);
    for (int k = 0; k < 6; k++) check($sformatf("coh_byte%0d", k), rd_buf[k], exp6[k]);
    do_read(6'h32, 2, -1);
    check("coh_next_xl", rd_buf[0], 8'hFF);
    check("coh_next_xh", rd_buf[1], 8'hFF);

    // reset while the target holds SDA low for DEVID bit 4
    bus_start();
    wr_byte(8'hA6, ack);
    wr_byte(8'h00, ack);
    bus_start();
    wr_byte(8'hA7, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
    clks(Q + 4);
    check("rstmid_target_driving", sda_bus === 1'b0, 1'b1);
    reset = 1'b1;
    clks(1);
    check("rstmid_sda_released", sda_bus !== 1'b0, 1'b1);
    clks(3);
    scl = 1'b1;
    reset = 1'b0;
    clks(2);
    check("rstmid_busy", busy, 1'b0);
    clks(2 * Q);
    do_read(6'h00, 1, -1);
    check("rstmid_after_acks", r_acks, 3'b000);
    check("rstmid_after_devid", rd_buf[0], 8'hE5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_accel_target.md
Name: i2c_accel_target

Overview:
- I2C target (slave) that emulates an ADXL345-style accelerometer at 7-bit address 0x53; it is the responder side of the accelerometer controller's I2C master.
- Used in simulation as a bus-accurate model and on FPGA as a loopback peer for the controller.
- Holds a small register file with DEVID, POWER_CTL, DATA_FORMAT and six data bytes loaded from a sample port.
- Supports register-pointer write, burst writes, repeated-START burst reads with pointer auto-increment, and STOP/START detection.

Parameters:
- DEV_ADDR, 7'h53, 7-bit target address matched on the bus.
- DEVID_VAL, 8'hE5, read-only value returned at register 0x00.
- HOLD_CYCLES, 4, clk cycles after a detected SCL fall before SDA is changed (must be < half the SCL period in clk cycles).
- FILTER_LEN, 3, glitch-filter depth, used only when the optional feature is enabled.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i2c_scl  in  1  bus clock; the target never stretches it.
- i2c_sda  inout  1  open-drain; driven 1'b0 or 1'bz only.
- sample_valid  in  1  one-cycle strobe that loads sample_x/y/z.
- sample_x  in  16  X sample.
- sample_y  in  16  Y sample.
- sample_z  in  16  Z sample.
- power_ctl  out  8  register 0x2D contents.
- data_format  out  8  register 0x31 contents.
- reg_wr_strobe  out  1  one-cycle pulse per register byte written.
- reg_wr_addr  out  6  register address of the last write.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Input sync: SCL and SDA each pass through 2 flops. Edge detect runs on the synced values.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- Reset values:
  - power_ctl=0, data_format=0, reg_wr_strobe=0, reg_wr_addr=0, busy=0.
  - Data registers=0, pointer=0, FSM=IDLE, SDA released.
- Register map (6-bit pointer):
  - 0x00 DEVID, read-only.
  - 0x2D and 0x31 read/write.
  - 0x32..0x37 = X_L, X_H, Y_L, Y_H, Z_L, Z_H, read-only.
  - All other addresses read 0x00; writes to them are ignored but still ACKed.
- Sample coherence:
  - sample_valid loads a shadow bank.
  - The shadow is copied to the readable data bank on every address-matched read header, so a burst always returns one coherent sample.
  - sample_valid arriving mid-burst affects only the next burst.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK.
  - START (including repeated START) from any state -> ADDR with bit count 0.
  - STOP from any state -> IDLE, SDA released, busy=0.
  - ADDR: shift 8 bits MSB-first on SCL rises.
    - Address mismatch -> IDLE; no ACK is driven.
    - Match -> ADDR_ACK.
  - ADDR_ACK: pull SDA low for the 9th SCL high.
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA, with byte[pointer] loaded.
  - PTR: 8 bits, pointer=byte[5:0]; then PTR_ACK -> WDATA.
  - WDATA: 8 bits; then WACK.
    - WACK writes the register, pulses reg_wr_strobe, sets reg_wr_addr, increments the pointer, returns to WDATA.
  - RDATA: drive each bit HOLD_CYCLES after the SCL fall; release SDA after bit 0. -> RACK.
  - RACK: sample the master's ACK on SCL rise.
    - ACK=0 -> pointer+1, load the next byte, RDATA.
    - NACK -> IDLE, waiting for STOP.
- Pointer wraps 0x3F -> 0x00.
- The ACK drive starts HOLD_CYCLES after the 8th-bit SCL fall and releases HOLD_CYCLES after the 9th SCL fall.
- SDA changes never occur while synced SCL is high.
- Reset asserted mid-transfer releases SDA in the same cycle it is sampled. The block ignores the bus until the next START.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: synced SCL/SDA additionally pass a FILTER_LEN-deep stability filter. The output changes only after FILTER_LEN equal consecutive samples, which suppresses sub-FILTER_LEN spikes. Latency grows by FILTER_LEN cycles, so HOLD_CYCLES must be > FILTER_LEN.
- Undefined: 2-flop synchronizer only.

Decomposition:
- Package i2c_accel_pkg holds:
  - the FSM state enum;
  - register address constants REG_DEVID=0x00, REG_POWER_CTL=0x2D, REG_DATA_FORMAT=0x31, REG_DATAX0=0x32;
  - the default DEV_ADDR.
- One sub-module, i2c_bus_sync: synchronizer, optional glitch filter, and START/STOP/SCL-edge detect.

Test Plan:
- Burst read: load sample X=0x1234, Y=0x5678, Z=0x9ABC. Master writes pointer 0x32, repeated START, reads 6 bytes with NACK on the last -> bytes 34 12 78 56 BC 9A; busy drops after STOP.
- DEVID read: pointer 0x00, read 1 byte -> 0xE5; all 3 ACKs observed low.
- Register write: write 0x2D, data 0x08, 0x0B burst -> power_ctl=0x08. The pointer then increments to 0x2E, so 0x0B is ignored but ACKed. reg_wr_strobe pulses twice and reg_wr_addr ends at 0x2E; data_format stays 0x00.
- Wrong address 0x1D -> SDA never driven low by the target; FSM stays IDLE; busy stays 0.
- Coherence: pulse sample_valid with X=0xFFFF during the 3rd byte of a burst -> that burst still returns the old sample; the next burst returns 0xFFFF.
- Reset mid-read while the target drives 0 -> SDA released within one cycle; the next full transaction succeeds.
